// File: rtl/membus_arbiter_if.sv
// Generic membus request/response bundle: one request channel and its single response strobe.
// The requester drives the request side (master); the responder drives ready and the response (slave).
interface membus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, addr, wen, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, addr, wen, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/membus_arbiter.sv
// Two-requester membus arbiter: instruction fetch (p0) and data load/store (p1) share one
// downstream membus. One transaction is outstanding at a time and its response is steered back
// to the owner. Requests and responses pass through combinationally; no pipeline stage is added.
module membus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    membus_arbiter_if.slave     p0,
    membus_arbiter_if.slave     p1,
    membus_arbiter_if.master    d,
    output logic                busy,
    output logic                owner,
    output logic                err_stray
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              lastGrant_q, lastGrant_d;
    logic              errStray_q, errStray_d;

    logic              sel;
    logic              selValid;
    logic              selWen;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              isIdle;
    logic              isBusy;

    // Pick the port to present downstream this cycle; with round-robin the port that did not win last time gets the tie.
    always_comb begin
        sel = 1'b0;
        if (PRIO_MODE != 0) begin
            sel = p1.valid;
        end else if (p0.valid && p1.valid) begin
            sel = ~lastGrant_q;
        end else begin
            sel = p1.valid;
        end
    end

    // Mux the chosen port onto the downstream request and route the handshake back; responses go to the owner only.
    always_comb begin
        isIdle   = (state_q == IDLE) && ARESETN;
        isBusy   = (state_q == BUSY);
        selValid = sel ? p1.valid : p0.valid;
        selWen   = sel ? p1.wen   : p0.wen;
        selAddr  = sel ? p1.addr  : p0.addr;
        selWdata = sel ? p1.wdata : p0.wdata;

        d.valid  = isIdle & selValid;
        d.addr   = selAddr;
        d.wen    = selWen;
        d.wdata  = selWdata;

        p0.ready = isIdle & ~sel & d.ready;
        p1.ready = isIdle &  sel & d.ready;

        p0.rvalid = isBusy & ~owner_q & d.rvalid;
        p1.rvalid = isBusy &  owner_q & d.rvalid;
        p0.rdata  = d.rdata;
        p1.rdata  = d.rdata;
    end

    // Next-state: accept a handshake in IDLE, return to IDLE on the response, flag responses nobody asked for.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        errStray_d  = errStray_q;
        case (state_q)
            IDLE: begin
                if (selValid && d.ready) begin
                    state_d     = BUSY;
                    owner_d     = sel;
                    lastGrant_d = sel;
                end
                if (d.rvalid) begin
                    errStray_d = 1'b1;
                end
            end
            BUSY: begin
                if (d.rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any outstanding transaction so its response is treated as stray.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            errStray_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            errStray_q  <= errStray_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign owner     = owner_q;
    assign err_stray = errStray_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: one round-robin and one fixed-priority instance share the same
// stimulus; a transaction-level model per instance predicts every output each cycle, and
// directed sequences pin the model with literal expectations before a randomized run.
module tb_membus_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        p0Valid, p0Wen, p1Valid, p1Wen, dReady, dRvalid;
    logic [31:0] p0Addr, p0Wdata, p1Addr, p1Wdata, dRdata;

    int errors = 0;
    int checks = 0;

    int grantsA[$];
    int grantsB[$];

    // Free-running clock, period 10.
    always #5 ACLK = ~ACLK;

    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifP0A();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifP1A();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifDA();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifP0B();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifP1B();
    membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifDB();

    assign ifP0A.valid = p0Valid; assign ifP0A.addr = p0Addr; assign ifP0A.wen = p0Wen; assign ifP0A.wdata = p0Wdata;
    assign ifP1A.valid = p1Valid; assign ifP1A.addr = p1Addr; assign ifP1A.wen = p1Wen; assign ifP1A.wdata = p1Wdata;
    assign ifP0B.valid = p0Valid; assign ifP0B.addr = p0Addr; assign ifP0B.wen = p0Wen; assign ifP0B.wdata = p0Wdata;
    assign ifP1B.valid = p1Valid; assign ifP1B.addr = p1Addr; assign ifP1B.wen = p1Wen; assign ifP1B.wdata = p1Wdata;
    assign ifDA.ready = dReady; assign ifDA.rvalid = dRvalid; assign ifDA.rdata = dRdata;
    assign ifDB.ready = dReady; assign ifDB.rvalid = dRvalid; assign ifDB.rdata = dRdata;

    logic        dValidO[2], dWenO[2], p0ReadyO[2], p1ReadyO[2], p0RvalidO[2], p1RvalidO[2];
    logic        busyO[2], ownerO[2], errO[2];
    logic [31:0] dAddrO[2], dWdataO[2], p0RdataO[2], p1RdataO[2];

    assign dValidO[0] = ifDA.valid;     assign dValidO[1] = ifDB.valid;
    assign dWenO[0] = ifDA.wen;         assign dWenO[1] = ifDB.wen;
    assign dAddrO[0] = ifDA.addr;       assign dAddrO[1] = ifDB.addr;
    assign dWdataO[0] = ifDA.wdata;     assign dWdataO[1] = ifDB.wdata;
    assign p0ReadyO[0] = ifP0A.ready;   assign p0ReadyO[1] = ifP0B.ready;
    assign p1ReadyO[0] = ifP1A.ready;   assign p1ReadyO[1] = ifP1B.ready;
    assign p0RvalidO[0] = ifP0A.rvalid; assign p0RvalidO[1] = ifP0B.rvalid;
    assign p1RvalidO[0] = ifP1A.rvalid; assign p1RvalidO[1] = ifP1B.rvalid;
    assign p0RdataO[0] = ifP0A.rdata;   assign p0RdataO[1] = ifP0B.rdata;
    assign p1RdataO[0] = ifP1A.rdata;   assign p1RdataO[1] = ifP1B.rdata;

    membus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dutA (
        .ACLK(ACLK), .ARESETN(ARESETN), .p0(ifP0A), .p1(ifP1A), .d(ifDA),
        .busy(busyO[0]), .owner(ownerO[0]), .err_stray(errO[0])
    );

    membus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dutB (
        .ACLK(ACLK), .ARESETN(ARESETN), .p0(ifP0B), .p1(ifP1B), .d(ifDB),
        .busy(busyO[1]), .owner(ownerO[1]), .err_stray(errO[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                                 input logic v1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                                 input logic dr, input logic rv, input logic [31:0] rd);
        p0Valid = v0; p0Addr = a0; p0Wen = w0; p0Wdata = d0;
        p1Valid = v1; p1Addr = a1; p1Wen = w1; p1Wdata = d1;
        dReady = dr; dRvalid = rv; dRdata = rd;
    endtask

    task automatic nextCycle;
        @(posedge ACLK);
        #1;
    endtask

    // Transaction-level model per instance (index 0 round-robin, 1 fixed priority), checked every falling edge.
    bit mBusy[2], mOwner[2], mLast[2], mErr[2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            mBusy[m] = 0; mOwner[m] = 0; mLast[m] = 1; mErr[m] = 0;
        end
        forever begin
            @(negedge ACLK);
            for (int m = 0; m < 2; m++) begin
                bit       win;
                bit       dvExp;
                bit [1:0] reqs;
                bit [1:0] rdyExp;
                bit [1:0] rvExp;
                if (!ARESETN) begin
                    mBusy[m] = 0; mOwner[m] = 0; mLast[m] = 1; mErr[m] = 0;
                    checkOutput($sformatf("rstBusy%0d", m), busyO[m], 0);
                    checkOutput($sformatf("rstOwner%0d", m), ownerO[m], 0);
                    checkOutput($sformatf("rstErr%0d", m), errO[m], 0);
                    checkOutput($sformatf("rstDValid%0d", m), dValidO[m], 0);
                    checkOutput($sformatf("rstReady%0d", m), {p1ReadyO[m], p0ReadyO[m]}, 0);
                    checkOutput($sformatf("rstRvalid%0d", m), {p1RvalidO[m], p0RvalidO[m]}, 0);
                end else begin
                    reqs = {p1Valid, p0Valid};
                    if (m == 1) win = reqs[1];
                    else if (reqs == 2'b11) win = (mLast[m] == 1'b1) ? 1'b0 : 1'b1;
                    else win = reqs[1];
                    dvExp = 0; rdyExp = 0; rvExp = 0;
                    if (!mBusy[m]) begin
                        dvExp = reqs[win];
                        rdyExp[win] = dReady;
                    end else begin
                        rvExp[mOwner[m]] = dRvalid;
                    end
                    checkOutput($sformatf("busy%0d", m), busyO[m], mBusy[m]);
                    checkOutput($sformatf("owner%0d", m), ownerO[m], mOwner[m]);
                    checkOutput($sformatf("errStray%0d", m), errO[m], mErr[m]);
                    checkOutput($sformatf("dValid%0d", m), dValidO[m], dvExp);
                    checkOutput($sformatf("ready%0d", m), {p1ReadyO[m], p0ReadyO[m]}, rdyExp);
                    checkOutput($sformatf("rvalid%0d", m), {p1RvalidO[m], p0RvalidO[m]}, rvExp);
                    checkOutput($sformatf("p0Rdata%0d", m), p0RdataO[m], dRdata);
                    checkOutput($sformatf("p1Rdata%0d", m), p1RdataO[m], dRdata);
                    if (!mBusy[m]) begin
                        checkOutput($sformatf("dAddr%0d", m), dAddrO[m], win ? p1Addr : p0Addr);
                        checkOutput($sformatf("dWen%0d", m), dWenO[m], win ? p1Wen : p0Wen);
                        checkOutput($sformatf("dWdata%0d", m), dWdataO[m], win ? p1Wdata : p0Wdata);
                        if (dvExp && dReady) begin
                            mBusy[m] = 1; mOwner[m] = win; mLast[m] = win;
                        end
                        if (dRvalid) mErr[m] = 1;
                    end else if (dRvalid) begin
                        mBusy[m] = 0;
                    end
                end
            end
        end
    end

    // Record which port each instance actually granted, for the grant-order checks.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (p0ReadyO[0] && p0Valid) grantsA.push_back(0);
                if (p1ReadyO[0] && p1Valid) grantsA.push_back(1);
                if (p0ReadyO[1] && p0Valid) grantsB.push_back(0);
                if (p1ReadyO[1] && p1Valid) grantsB.push_back(1);
            end
        end
    end

    // Directed sequences with literal expectations, then a randomized run.
    initial begin
        int rrExp[6];
        int zerosB;
        rrExp = '{0, 1, 0, 1, 0, 1};
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ARESETN = 1'b0;
        repeat (3) nextCycle;
        ARESETN = 1'b1;
        @(negedge ACLK);
        checkOutput("litResetBusy", busyO[0], 0);
        checkOutput("litResetOwner", ownerO[0], 0);
        checkOutput("litResetErr", errO[0], 0);

        // Single port-0 read with a three-cycle response.
        nextCycle;
        applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge ACLK);
        checkOutput("litT1DValid", dValidO[0], 1);
        checkOutput("litT1DAddr", dAddrO[0], 32'h8000_0000);
        checkOutput("litT1P0Ready", p0ReadyO[0], 1);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("litT1Busy", busyO[0], 1);
        checkOutput("litT1P0ReadyLow", p0ReadyO[0], 0);
        nextCycle;
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
        @(negedge ACLK);
        checkOutput("litT1BusyStill", busyO[0], 1);
        checkOutput("litT1P0Rvalid", p0RvalidO[0], 1);
        checkOutput("litT1P0Rdata", p0RdataO[0], 32'h0000_0013);
        checkOutput("litT1P1Rvalid", p1RvalidO[0], 0);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("litT1Idle", busyO[0], 0);

        // Both ports continuously valid for six transactions.
        nextCycle;
        ARESETN = 1'b0;
        nextCycle;
        ARESETN = 1'b1;
        grantsA.delete();
        grantsB.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 32'h1000 + i, 0, 0, 1, 32'h2000 + i, 0, 0, 1, 0, 0);
            nextCycle;
            applyStimulus(1, 32'h1000 + i, 0, 0, 1, 32'h2000 + i, 0, 0, 1, 1, i);
            nextCycle;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("litRrCount", grantsA.size(), 6);
        for (int i = 0; i < 6 && i < grantsA.size(); i++) begin
            checkOutput($sformatf("litRrGrant%0d", i), grantsA[i], rrExp[i]);
        end
        zerosB = 0;
        foreach (grantsB[i]) if (grantsB[i] == 0) zerosB++;
        checkOutput("litPrioCount", grantsB.size(), 6);
        checkOutput("litPrioStarve", zerosB, 0);

        // Port-1 write with port 0 arriving while busy.
        nextCycle;
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 1, 0, 0);
        @(negedge ACLK);
        checkOutput("litWrP1Ready", p1ReadyO[0], 1);
        checkOutput("litWrDAddr", dAddrO[0], 32'h8000_0100);
        checkOutput("litWrDWen", dWenO[0], 1);
        checkOutput("litWrDWdata", dWdataO[0], 32'hDEAD_BEEF);
        nextCycle;
        applyStimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            checkOutput("litWrP0Blocked", p0ReadyO[0], 0);
            checkOutput("litWrDValidLow", dValidO[0], 0);
            nextCycle;
        end
        applyStimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        @(negedge ACLK);
        checkOutput("litWrP1Rvalid", p1RvalidO[0], 1);
        checkOutput("litWrP0Rvalid", p0RvalidO[0], 0);
        checkOutput("litWrP0StillBlocked", p0ReadyO[0], 0);
        nextCycle;
        applyStimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge ACLK);
        checkOutput("litWrP0Accept", p0ReadyO[0], 1);
        checkOutput("litWrP0Addr", dAddrO[0], 32'h8000_0200);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nextCycle;

        // Downstream stall with port 0 held valid.
        applyStimulus(1, 32'h8000_0300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput("litStallDValid", dValidO[0], 1);
            checkOutput("litStallDAddr", dAddrO[0], 32'h8000_0300);
            checkOutput("litStallBusy", busyO[0], 0);
            nextCycle;
        end
        dReady = 1'b1;
        @(negedge ACLK);
        checkOutput("litStallAccept", p0ReadyO[0], 1);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge ACLK);
        checkOutput("litStallBusyAfter", busyO[0], 1);
        nextCycle;

        // Stray response in IDLE, then reset in the middle of a transaction.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        @(negedge ACLK);
        checkOutput("litStrayRvalid", {p1RvalidO[0], p0RvalidO[0]}, 0);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("litStraySet", errO[0], 1);
        nextCycle;
        applyStimulus(1, 32'h8000_0400, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge ACLK);
        checkOutput("litStrayStays", errO[0], 1);
        nextCycle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        checkOutput("litPreRstBusy", busyO[0], 1);
        nextCycle;
        ARESETN = 1'b0;
        #1;
        checkOutput("litAsyncRstBusy", busyO[0], 0);
        checkOutput("litAsyncRstErr", errO[0], 0);
        nextCycle;
        ARESETN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        @(negedge ACLK);
        checkOutput("litPostRstRvalid", {p1RvalidO[0], p0RvalidO[0]}, 0);
        nextCycle;

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1), $urandom,
                          $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1), $urandom,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
            ARESETN = ($urandom_range(0, 399) != 0);
            nextCycle;
        end
        ARESETN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle;
        @(negedge ACLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares the single downstream membus (feeding the AXI read/write adapter) between two upstream membus requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Grants one request at a time and tracks the single outstanding transaction.
- Steers the response back to the owning port.
- Sits between core_port and the AXI adapter in top.

Parameters:
- ADDR_W, 32, address width of all membus ports
- DATA_W, 32, data width of wdata/rdata
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 always wins

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- p0_valid, p1_valid  in  1  upstream request valid
- p0_ready, p1_ready  out  1  upstream request accepted
- p0_addr, p1_addr  in  ADDR_W  request address
- p0_wen, p1_wen  in  1  1 = write
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_rvalid, p1_rvalid  out  1  response strobe to owner
- p0_rdata, p1_rdata  out  DATA_W  response data
- d_valid  out  1  downstream request valid
- d_ready  in  1  downstream accept
- d_addr  out  ADDR_W  muxed address
- d_wen  out  1  muxed write enable
- d_wdata  out  DATA_W  muxed write data
- d_rvalid  in  1  downstream response strobe (exactly one per accepted request, reads and writes)
- d_rdata  in  DATA_W  downstream response data
- busy  out  1  transaction outstanding
- owner  out  1  port owning the current or last transaction
- err_stray  out  1  sticky: d_rvalid seen while IDLE

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state = IDLE, owner = 0, last_grant = 1 (so port 0 wins first round-robin tie), busy = 0, err_stray = 0.
  - All ready/rvalid outputs 0; d_valid = 0.
  - Asserting reset mid-transaction drops ownership; no response is ever delivered for that transaction.
- States: IDLE, BUSY.
- IDLE:
  - sel is computed combinationally from p0_valid/p1_valid.
  - PRIO_MODE=0: if both are valid, sel = ~last_grant; otherwise sel = the single valid port.
  - PRIO_MODE=1: sel = 1 if p1_valid, else 0.
  - d_valid = valid of sel; d_addr/d_wen/d_wdata = sel's fields (port 0 fields when neither is valid).
  - p<sel>_ready = d_ready; the other port's ready = 0.
  - On d_valid && d_ready: owner <= sel, last_grant <= sel, state <= BUSY, busy <= 1.
- BUSY:
  - d_valid = 0; both upstream readies = 0.
  - p<owner>_rvalid = d_rvalid (combinational pass-through); the other port's rvalid = 0.
  - Both rdata outputs = d_rdata at all times.
  - On d_rvalid: state <= IDLE, busy <= 0.
  - Next grant is no earlier than the following cycle: minimum one idle cycle between a response and the next accept.
- d_rvalid while IDLE: ignored (no upstream rvalid); err_stray <= 1 until reset.
- A granted requester may deassert valid before d_ready; the arbitration choice is re-evaluated each IDLE cycle. No request is ever latched without a handshake.
- Upstream valid held during BUSY is not accepted and not lost; it is arbitrated on return to IDLE.
- Round-robin guarantee: with both ports continuously valid, grants strictly alternate 0,1,0,1…
- Latency: request to downstream is zero-cycle combinational; response to upstream is zero-cycle combinational. The arbiter adds no pipeline stage.

Test Plan:
- Single port 0 read addr 0x8000_0000, d_ready=1, d_rvalid 3 cycles later with rdata 0x0000_0013 -> p0_ready pulses 1 cycle, busy high 3 cycles, p0_rvalid=1 with p0_rdata=0x13, p1_rvalid stays 0.
- PRIO_MODE=0, both valid continuously for 6 transactions, 1-cycle response latency -> grant order 0,1,0,1,0,1; owner matches each response.
- PRIO_MODE=1, both valid continuously -> port 1 granted every transaction; port 0 starves, ready never asserted.
- Port 1 write (wen=1, addr 0x8000_0100, wdata 0xDEAD_BEEF) while port 0 valid arrives mid-BUSY -> port 0 not accepted until one cycle after write's d_rvalid; write's d_rvalid goes only to p1_rvalid.
- d_ready low 4 cycles with p0_valid held -> d_valid held, d_addr stable, no state change; accept on first d_ready=1 cycle.
- d_rvalid pulsed in IDLE -> no upstream rvalid, err_stray=1 and stays set; ARESETN low mid-BUSY -> busy=0, err_stray=0 immediately, later d_rvalid produces no p*_rvalid.
